// File: rtl/unsaved_nios2_gen2_1_cpu_ocimem_arb_if.sv
// Avalon debug-slave bus between the CPU and the OCIMEM arbiter.
interface unsaved_nios2_gen2_1_cpu_ocimem_arb_if;
  logic [8:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        debugaccess;
  logic [31:0] readdata;
  logic        waitrequest;

  modport master (
    output address, read, write, writedata, byteenable, debugaccess,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, read, write, writedata, byteenable, debugaccess,
    output readdata, waitrequest
  );
endinterface

// File: rtl/unsaved_nios2_gen2_1_cpu_ocimem_arb.sv
// OCIMEM stage: 256x32 debug RAM shared between JTAG commands and the CPU
// Avalon debug slave, plus the monitor handshake flags.
module unsaved_nios2_gen2_1_cpu_ocimem_arb (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic [37:0]                           jdo,
  input  logic                                  take_action_ocimem_a,
  input  logic                                  take_no_action_ocimem_a,
  input  logic                                  take_action_ocimem_b,
  unsaved_nios2_gen2_1_cpu_ocimem_arb_if.slave  bus,
  output logic [31:0]                           MonDReg,
  output logic                                  monitor_ready,
  output logic                                  monitor_error,
  output logic                                  monitor_go
);

  localparam int unsigned RAM_AW    = 8;
  localparam int unsigned RAM_DEPTH = 1 << RAM_AW;
  localparam int unsigned DW        = 32;
  localparam int unsigned BW        = DW / 8;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_JTAG_RD = 2'd1;
  localparam logic [1:0] S_CPU_RD  = 2'd2;

  typedef struct packed {
    logic              valid;
    logic              wr;
    logic [RAM_AW-1:0] addr;
    logic [DW-1:0]     data;
  } jtag_cmd_t;

  logic [1:0]        state, state_nxt;
  jtag_cmd_t         pend;
  logic [RAM_AW-1:0] mon_areg;
  logic [DW-1:0]     ram_q;
  logic [DW-1:0]     reg_q;
  logic              rd_is_reg;

  logic              ram_en, ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [DW-1:0]     ram_wdata;
  logic [BW-1:0]     ram_be;
  logic              jtag_issue, jtag_wr_commit, cpu_rd_issue, cpu_reg_wr;

  logic [DW-1:0]     mem [RAM_DEPTH];

  logic              unused_jdo;
  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next state and RAM port arbitration; a pending JTAG command beats the CPU
  always_comb begin
    state_nxt      = state;
    ram_en         = 1'b0;
    ram_we         = 1'b0;
    ram_addr       = pend.addr;
    ram_wdata      = pend.data;
    ram_be         = '1;
    jtag_issue     = 1'b0;
    jtag_wr_commit = 1'b0;
    cpu_rd_issue   = 1'b0;
    cpu_reg_wr     = 1'b0;
    case (state)
      S_IDLE: begin
        if (pend.valid) begin
          jtag_issue = 1'b1;
          ram_en     = 1'b1;
          ram_we     = pend.wr;
          if (pend.wr) jtag_wr_commit = 1'b1;
          else         state_nxt      = S_JTAG_RD;
        end else if (bus.read) begin
          cpu_rd_issue = 1'b1;
          state_nxt    = S_CPU_RD;
          if (!bus.address[8]) begin
            ram_en   = 1'b1;
            ram_addr = bus.address[RAM_AW-1:0];
          end
        end else if (bus.write) begin
          if (!bus.address[8]) begin
            ram_en    = bus.debugaccess;
            ram_we    = bus.debugaccess;
            ram_addr  = bus.address[RAM_AW-1:0];
            ram_wdata = bus.writedata;
            ram_be    = bus.byteenable;
          end else begin
            cpu_reg_wr = (bus.address[7:0] == 8'h00);
          end
        end
      end
      S_JTAG_RD: state_nxt = S_IDLE;
      S_CPU_RD:  state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Single-port RAM, byte-lane writes, registered read data, contents not reset
  always_ff @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        for (int unsigned b = 0; b < BW; b++) begin
          if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
      end
      ram_q <= mem[ram_addr];
    end
  end

  // JTAG command capture; a newer strobe overwrites an unserved one
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend     <= '0;
      mon_areg <= '0;
    end else begin
      if (take_action_ocimem_a) begin
        pend     <= '{valid: 1'b1, wr: 1'b0, addr: jdo[33:26], data: '0};
        mon_areg <= jdo[33:26];
      end else if (take_no_action_ocimem_a) begin
        pend     <= '{valid: 1'b1, wr: 1'b0, addr: mon_areg + RAM_AW'(1), data: '0};
        mon_areg <= mon_areg + RAM_AW'(1);
      end else if (take_action_ocimem_b) begin
        pend     <= '{valid: 1'b1, wr: 1'b1, addr: mon_areg, data: jdo[34:3]};
      end else begin
        if (jtag_issue)     pend.valid <= 1'b0;
        if (jtag_wr_commit) mon_areg   <= mon_areg + RAM_AW'(1);
      end
    end
  end

  // JTAG data return and monitor flags; a CPU status write clears go over a set
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      MonDReg       <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
      monitor_go    <= 1'b0;
    end else begin
      if (jtag_wr_commit)          MonDReg <= pend.data;
      else if (state == S_JTAG_RD) MonDReg <= ram_q;
      if (cpu_reg_wr) begin
        monitor_ready <= bus.writedata[0];
        monitor_error <= bus.writedata[1];
        monitor_go    <= 1'b0;
      end else if (take_action_ocimem_a && jdo[25]) begin
        monitor_go    <= 1'b1;
      end
    end
  end

  // Register-space read snapshot taken when the CPU read is issued
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_is_reg <= 1'b0;
      reg_q     <= '0;
    end else if (cpu_rd_issue) begin
      rd_is_reg <= bus.address[8];
      reg_q     <= (bus.address[8] && bus.address[7:0] == 8'h00)
                   ? {30'b0, monitor_error, monitor_ready} : '0;
    end
  end

  assign bus.readdata    = (state == S_CPU_RD) ? (rd_is_reg ? reg_q : ram_q) : '0;
  assign bus.waitrequest = (bus.read | bus.write) &
                           (pend.valid | (state == S_JTAG_RD) | ((state == S_IDLE) & bus.read));

endmodule

// File: tb/tb_unsaved_nios2_gen2_1_cpu_ocimem_arb.sv
// Scoreboard bench for the OCIMEM arbiter: directed JTAG and CPU traffic.
module tb_unsaved_nios2_gen2_1_cpu_ocimem_arb;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error, monitor_go;

  unsaved_nios2_gen2_1_cpu_ocimem_arb_if bus ();

  unsaved_nios2_gen2_1_cpu_ocimem_arb dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .bus                     (bus.slave),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error),
    .monitor_go              (monitor_go)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   tests  = 0;
  int   failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every accepted CPU read is compared against the oldest expectation
  always @(negedge clk) begin
    if (reset_n === 1'b1 && bus.read === 1'b1 && bus.waitrequest === 1'b0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_readdata", bus.readdata, 32'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check(e.name, bus.readdata, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic jtag_a(input logic [7:0] addr, input logic go);
    logic [37:0] j;
    j = '0;
    j[33:26] = addr;
    j[25]    = go;
    jdo = j;
    take_action_ocimem_a = 1'b1;
    @(posedge clk); #1;
    take_action_ocimem_a = 1'b0;
  endtask

  task automatic jtag_b(input logic [31:0] data);
    jdo = 38'(data) << 3;
    take_action_ocimem_b = 1'b1;
    @(posedge clk); #1;
    take_action_ocimem_b = 1'b0;
  endtask

  task automatic cpu_write(input logic [8:0] a, input logic [31:0] d, input logic [3:0] be,
                           input logic dbg, output int waits);
    bus.address = a; bus.writedata = d; bus.byteenable = be; bus.debugaccess = dbg;
    bus.write = 1'b1;
    waits = 0;
    forever begin
      @(negedge clk);
      if (bus.waitrequest === 1'b0) break;
      waits++;
      if (waits > 20) begin
        check("write_wait_timeout", 32'(waits), 32'd0);
        break;
      end
    end
    @(posedge clk); #1;
    bus.write = 1'b0;
  endtask

  task automatic cpu_read(input logic [8:0] a, input logic [31:0] exp, input string name,
                          output int waits);
    exp_q.push_back('{name: name, data: exp});
    bus.address = a;
    bus.read = 1'b1;
    waits = 0;
    forever begin
      @(negedge clk);
      if (bus.waitrequest === 1'b0) break;
      waits++;
      if (waits > 20) begin
        check("read_wait_timeout", 32'(waits), 32'd0);
        void'(exp_q.pop_back());
        break;
      end
    end
    @(posedge clk); #1;
    bus.read = 1'b0;
  endtask

  int w;

  initial begin
    reset_n = 1'b0;
    jdo = '0;
    take_action_ocimem_a = 1'b0; take_no_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0;
    bus.address = '0; bus.read = 1'b0; bus.write = 1'b0;
    bus.writedata = '0; bus.byteenable = '0; bus.debugaccess = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mondreg", MonDReg, 32'h0);
    check("rst_readdata", bus.readdata, 32'h0);
    check("rst_flags", {29'b0, monitor_go, monitor_error, monitor_ready}, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_waitrequest", 32'(bus.waitrequest), 32'h0);
    @(posedge clk); #1;

    // JTAG write then read-back with edge-3 timing
    jtag_a(8'h10, 1'b0); idle(3);
    jtag_b(32'hDEADBEEF); idle(1);
    check("jtag_wr_mondreg", MonDReg, 32'hDEADBEEF);
    jtag_b(32'hCAFEF00D); idle(1);
    check("jtag_wr2_mondreg", MonDReg, 32'hCAFEF00D);
    idle(1);
    jtag_a(8'h10, 1'b0); idle(1);
    check("jtag_rd_edge2_hold", MonDReg, 32'hCAFEF00D);
    idle(1);
    check("jtag_rd_edge3", MonDReg, 32'hDEADBEEF);
    check("go_not_set", 32'(monitor_go), 32'h0);
    cpu_read(9'h010, 32'hDEADBEEF, "cpu_rd_0x10", w);
    check("cpu_rd_waits", 32'(w), 32'd1);
    cpu_read(9'h011, 32'hCAFEF00D, "cpu_rd_0x11", w);

    // CPU byte-enabled write, then write ignored without debugaccess
    cpu_write(9'h005, 32'hFFFFFFFF, 4'hF, 1'b1, w);
    check("cpu_wr_waits", 32'(w), 32'd0);
    cpu_write(9'h005, 32'h12345678, 4'h3, 1'b1, w);
    cpu_read(9'h005, 32'hFFFF5678, "cpu_be_write", w);
    check("cpu_rd_waits2", 32'(w), 32'd1);
    cpu_write(9'h005, 32'h00000000, 4'hF, 1'b0, w);
    cpu_read(9'h005, 32'hFFFF5678, "cpu_nodbg_write", w);

    // MonAReg wraps 0xFF -> 0x00
    jtag_a(8'hFF, 1'b0); idle(3);
    jtag_b(32'h000000A1); idle(2);
    jtag_b(32'h000000B2); idle(2);
    jtag_b(32'h000000C3); idle(2);
    cpu_read(9'h0FF, 32'h000000A1, "wrap_0xff", w);
    cpu_read(9'h000, 32'h000000B2, "wrap_0x00", w);
    cpu_read(9'h001, 32'h000000C3, "wrap_0x01", w);

    // CPU read stalled behind a pending JTAG write sees the new data
    jtag_a(8'h10, 1'b0); idle(3);
    jtag_b(32'h55AA55AA);
    cpu_read(9'h010, 32'h55AA55AA, "contention_data", w);
    check("contention_waits", 32'(w), 32'd2);

    // Monitor handshake flags
    jtag_a(8'h20, 1'b1);
    check("go_set", 32'(monitor_go), 32'h1);
    idle(3);
    cpu_write(9'h100, 32'h00000003, 4'hF, 1'b0, w);
    check("status_wr_flags", {29'b0, monitor_go, monitor_error, monitor_ready}, 32'h3);
    cpu_read(9'h100, 32'h00000003, "status_rd", w);
    cpu_read(9'h104, 32'h00000000, "reg_other_rd", w);
    cpu_write(9'h104, 32'h00000000, 4'hF, 1'b1, w);
    check("reg_other_wr_ignored", {29'b0, monitor_go, monitor_error, monitor_ready}, 32'h3);
    fork
      jtag_a(8'h20, 1'b1);
      cpu_write(9'h100, 32'h00000001, 4'hF, 1'b1, w);
    join
    check("clear_beats_set", {29'b0, monitor_go, monitor_error, monitor_ready}, 32'h1);
    idle(3);

    // Reset while a JTAG write is pending
    cpu_write(9'h030, 32'h11111111, 4'hF, 1'b1, w);
    jtag_a(8'h30, 1'b0); idle(3);
    check("jtag_rd_0x30", MonDReg, 32'h11111111);
    jtag_b(32'h99999999);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_mondreg", MonDReg, 32'h0);
    check("midrst_flags", {29'b0, monitor_go, monitor_error, monitor_ready}, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle(2);
    cpu_read(9'h030, 32'h11111111, "midrst_no_write", w);

    idle(3);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
